// File: rtl/zf_pkg.sv
// Shared definitions for the ZF stages: FSM state codes, complex field ranges,
// per-stage strobe bundle and an FP32 sign-flip helper.
package zf_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MUL_Z2   = 3'd1;
    localparam logic [2:0] S_MUL_DIAG = 3'd2;
    localparam logic [2:0] S_ACC_A    = 3'd3;
    localparam logic [2:0] S_ACC_B    = 3'd4;
    localparam logic [2:0] S_READY    = 3'd5;

    localparam int RE_HI = 63;
    localparam int RE_LO = 32;
    localparam int IM_HI = 31;
    localparam int IM_LO = 0;

    typedef struct packed {
        logic cap;
        logic z2;
        logic diag;
        logic acca;
        logic accb;
    } stage_t;

    function automatic logic [31:0] fp_neg(input logic [31:0] v);
        return {~v[31], v[30:0]};
    endfunction

endpackage

// File: rtl/remodulate_zf_controller.sv
// Sequencer for z = R*x: walks the fixed five-step schedule and exposes the
// IDLE/READY handshake plus one-hot stage strobes for the datapath.
module remodulate_zf_controller
    import zf_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   enable,
    input  logic   accept_in,
    output logic   accept_out,
    output logic   ready_out,
    output stage_t stage_o
);
    logic [2:0] state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (enable) state_d = S_MUL_Z2;
            S_MUL_Z2:   state_d = S_MUL_DIAG;
            S_MUL_DIAG: state_d = S_ACC_A;
            S_ACC_A:    state_d = S_ACC_B;
            S_ACC_B:    state_d = S_READY;
            S_READY:    if (accept_in) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept_out   = (state_q == S_IDLE);
        ready_out    = (state_q == S_READY);
        stage_o      = '0;
        stage_o.cap  = (state_q == S_IDLE) && enable;
        stage_o.z2   = (state_q == S_MUL_Z2);
        stage_o.diag = (state_q == S_MUL_DIAG);
        stage_o.acca = (state_q == S_ACC_A);
        stage_o.accb = (state_q == S_ACC_B);
    end
endmodule

// File: rtl/remodulate_zf_datapath.sv
// Operand capture, two shared mul->add lanes (re/im) and the Z result register.
module remodulate_zf_datapath
    import zf_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  stage_t        stage_i,
    input  logic [127:0]  x_i,
    input  logic [63:0]   rdiag_i,
    input  logic [63:0]   roff_i,
    output logic [127:0]  z_o
);
    logic [63:0]  x1_q, x2_q, roff_q;
    logic [31:0]  r11_q, r22_q, z2re_q, z2im_q, accre_q, accim_q;
    logic [127:0] z_q, z_d;
    logic [31:0]  m0a, m0b, m1a, m1b, p0, p1, s0b, s0, s1;

    always_comb begin
        m0a = '0; m0b = '0; m1a = '0; m1b = '0;
        if (stage_i.z2) begin
            m0a = r22_q;               m0b = x2_q[RE_HI:RE_LO];
            m1a = r22_q;               m1b = x2_q[IM_HI:IM_LO];
        end else if (stage_i.diag) begin
            m0a = r11_q;               m0b = x1_q[RE_HI:RE_LO];
            m1a = r11_q;               m1b = x1_q[IM_HI:IM_LO];
        end else if (stage_i.acca) begin
            m0a = roff_q[RE_HI:RE_LO]; m0b = x2_q[RE_HI:RE_LO];
            m1a = roff_q[RE_HI:RE_LO]; m1b = x2_q[IM_HI:IM_LO];
        end else if (stage_i.accb) begin
            m0a = roff_q[IM_HI:IM_LO]; m0b = x2_q[IM_HI:IM_LO];
            m1a = roff_q[IM_HI:IM_LO]; m1b = x2_q[RE_HI:RE_LO];
        end
        // real lane subtracts r12im*x2im in the last step
        s0b = stage_i.accb ? fp_neg(p0) : p0;
        z_d = {s0, s1, z2re_q, z2im_q};
    end

    zf_fp_mul u_mul0 (.a_i(m0a),     .b_i(m0b), .y_o(p0));
    zf_fp_mul u_mul1 (.a_i(m1a),     .b_i(m1b), .y_o(p1));
    zf_fp_add u_add0 (.a_i(accre_q), .b_i(s0b), .y_o(s0));
    zf_fp_add u_add1 (.a_i(accim_q), .b_i(p1),  .y_o(s1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x1_q <= '0; x2_q <= '0; roff_q <= '0; r11_q <= '0; r22_q <= '0;
            z2re_q <= '0; z2im_q <= '0; accre_q <= '0; accim_q <= '0; z_q <= '0;
        end else begin
            if (stage_i.cap) begin
                x1_q   <= x_i[127:64];
                x2_q   <= x_i[63:0];
                r11_q  <= rdiag_i[RE_HI:RE_LO];
                r22_q  <= rdiag_i[IM_HI:IM_LO];
                roff_q <= roff_i;
            end
            if (stage_i.z2)   begin z2re_q  <= p0; z2im_q  <= p1; end
            if (stage_i.diag) begin accre_q <= p0; accim_q <= p1; end
            if (stage_i.acca) begin accre_q <= s0; accim_q <= s1; end
            if (stage_i.accb) z_q <= z_d;
        end
    end

    assign z_o = z_q;
endmodule

// File: rtl/zf_fp_cells.sv
// FP32 multiply and add cells: truncating, denormals flushed to zero,
// NaN/Inf propagated with a canonical quiet NaN.
module zf_fp_mul (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);
    logic        s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [47:0] prod;
    logic [9:0]  e;
    logic [22:0] mant;
    logic        unused_bits;

    assign prod = {24'b0, 1'b1, a_i[22:0]} * {24'b0, 1'b1, b_i[22:0]};
    assign unused_bits = ^prod[22:0];

    always_comb begin
        s      = a_i[31] ^ b_i[31];
        nan_a  = (&a_i[30:23]) && (|a_i[22:0]);
        nan_b  = (&b_i[30:23]) && (|b_i[22:0]);
        inf_a  = (&a_i[30:23]) && !(|a_i[22:0]);
        inf_b  = (&b_i[30:23]) && !(|b_i[22:0]);
        zero_a = (a_i[30:23] == 8'd0);
        zero_b = (b_i[30:23] == 8'd0);
        e      = {2'b00, a_i[30:23]} + {2'b00, b_i[30:23]} - 10'd127 + {9'b0, prod[47]};
        mant   = prod[47] ? prod[46:24] : prod[45:23];
        if (nan_a || nan_b)                 y_o = 32'h7FC0_0000;
        else if (inf_a || inf_b)            y_o = (zero_a || zero_b) ? 32'h7FC0_0000 : {s, 8'hFF, 23'b0};
        else if (zero_a || zero_b)          y_o = {s, 31'b0};
        else if ($signed(e) <= 10'sd0)      y_o = {s, 31'b0};
        else if ($signed(e) >= 10'sd255)    y_o = {s, 8'hFF, 23'b0};
        else                                y_o = {s, e[7:0], mant};
    end
endmodule

module zf_fp_add (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);
    logic [31:0] big, sml;
    logic [7:0]  eb, es, d;
    logic [25:0] mb, ms, norm;
    logic [26:0] sum;
    logic [4:0]  pos, lz;
    logic [9:0]  e;
    logic [22:0] mant;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic        unused_bits;

    assign unused_bits = ^{norm[25], norm[1:0]};

    always_comb begin
        nan_a = (&a_i[30:23]) && (|a_i[22:0]);
        nan_b = (&b_i[30:23]) && (|b_i[22:0]);
        inf_a = (&a_i[30:23]) && !(|a_i[22:0]);
        inf_b = (&b_i[30:23]) && !(|b_i[22:0]);
        // larger magnitude first so the aligned difference is never negative
        if (b_i[30:0] > a_i[30:0]) begin
            big = b_i; sml = a_i;
        end else begin
            big = a_i; sml = b_i;
        end
        eb  = big[30:23];
        es  = sml[30:23];
        d   = eb - es;
        mb  = (eb != 8'd0) ? {1'b1, big[22:0], 2'b00} : 26'd0;
        ms  = (es != 8'd0) ? {1'b1, sml[22:0], 2'b00} : 26'd0;
        ms  = ms >> d;
        sum = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
        pos = '0;
        for (int i = 0; i < 26; i++) if (sum[i]) pos = 5'(i);
        lz   = 5'd25 - pos;
        norm = '0;
        if (sum[26]) begin
            mant = sum[25:3];
            e    = {2'b00, eb} + 10'd1;
        end else begin
            norm = sum[25:0] << lz;
            mant = norm[24:2];
            e    = {2'b00, eb} - {5'b0, lz};
        end
        if (nan_a || nan_b || (inf_a && inf_b && (a_i[31] != b_i[31]))) y_o = 32'h7FC0_0000;
        else if (inf_a)                       y_o = a_i;
        else if (inf_b)                       y_o = b_i;
        else if (sum == 27'd0)                y_o = 32'd0;
        else if ($signed(e) <= 10'sd0)        y_o = {big[31], 31'b0};
        else if ($signed(e) >= 10'sd255)      y_o = {big[31], 8'hFF, 23'b0};
        else                                  y_o = {big[31], e[7:0], mant};
    end
endmodule

// File: rtl/remodulate_zf.sv
// Forward ZF stage: z = R*x for the 2x2 complex upper-triangular R, FP32,
// using the same enable/accept_out and ready_out/accept_in handshake as its peers.
module remodulate_zf
    import zf_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    output logic         accept_out,
    output logic         ready_out,
    input  logic         accept_in,
    input  logic [127:0] X,
    input  logic [63:0]  R_diag,
    input  logic [63:0]  R_off,
    output logic [127:0] Z
);
    stage_t stage;

    remodulate_zf_controller u_ctrl (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .accept_in  (accept_in),
        .accept_out (accept_out),
        .ready_out  (ready_out),
        .stage_o    (stage)
    );

    remodulate_zf_datapath u_dp (
        .clk     (clk),
        .reset_n (reset_n),
        .stage_i (stage),
        .x_i     (X),
        .rdiag_i (R_diag),
        .roff_i  (R_off),
        .z_o     (Z)
    );
endmodule

// File: tb/tb_remodulate_zf.sv
// Scoreboard bench for remodulate_zf: directed jobs push expected Z and ready
// cycle; a negedge monitor pops on each ready_out rise and compares.
module tb_remodulate_zf;
    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         enable = 1'b0;
    logic         accept_in = 1'b0;
    logic         accept_out, ready_out;
    logic [127:0] X = '0;
    logic [63:0]  R_diag = '0;
    logic [63:0]  R_off = '0;
    logic [127:0] Z;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic [127:0] z;
        int           cyc;
    } exp_t;
    exp_t q[$];
    exp_t ex;
    logic prev_rdy = 1'b0;

    localparam logic [63:0]  RD_A  = {32'h4000_0000, 32'h3F80_0000};     // r11=2, r22=1
    localparam logic [63:0]  RO_A  = {32'h3F00_0000, 32'h3F00_0000};     // r12=0.5+0.5j
    localparam logic [63:0]  RD_B  = {32'h3F80_0000, 32'h4000_0000};     // r11=1, r22=2
    localparam logic [63:0]  RO_B  = {32'h3F80_0000, 32'hBF80_0000};     // r12=1-1j
    localparam logic [127:0] X_NOM = {32'h3F80_0000, 32'h0, 32'h0, 32'h3F80_0000};
    localparam logic [127:0] Z_NOM = {32'h3FC0_0000, 32'h3F00_0000, 32'h0, 32'h3F80_0000};
    localparam logic [127:0] X_SGN = {32'h3F80_0000, 32'h0, 32'hBF80_0000, 32'h0};
    localparam logic [127:0] Z_SGN = {32'h3FC0_0000, 32'hBF00_0000, 32'hBF80_0000, 32'h0};
    localparam logic [127:0] X_BB  = {32'h0, 32'h3F80_0000, 32'h3F80_0000, 32'h0};
    localparam logic [127:0] Z_BB  = {32'h3F00_0000, 32'h4020_0000, 32'h3F80_0000, 32'h0};
    localparam logic [127:0] X_ALT = {32'h3F80_0000, 32'h0, 32'h3F80_0000, 32'h3F80_0000};
    localparam logic [127:0] Z_ALT = {32'h4040_0000, 32'h0, 32'h4000_0000, 32'h4000_0000};
    localparam logic [127:0] X_JNK = {4{32'h4040_0000}};

    remodulate_zf dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .accept_out (accept_out),
        .ready_out  (ready_out),
        .accept_in  (accept_in),
        .X          (X),
        .R_diag     (R_diag),
        .R_off      (R_off),
        .Z          (Z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready_out && !prev_rdy) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: ready_out rose with Z=%h, expected no result", Z);
            end else begin
                ex = q.pop_front();
                chk("Z", Z, ex.z);
                chk("ready_latency", 128'(cyc), 128'(ex.cyc));
            end
        end
        prev_rdy = ready_out;
    end

    task automatic set_in(input logic [127:0] x, input logic [63:0] rd, input logic [63:0] ro);
        X = x; R_diag = rd; R_off = ro;
    endtask

    task automatic start_job(input logic [127:0] ez);
        exp_t e;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        e.z = ez; e.cyc = cyc + 4;
        q.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (!ready_out) begin
            n_fail++;
            $display("FAIL ready_timeout: ready_out=%0b after %0d cycles, expected 1", ready_out, n);
        end
    endtask

    task automatic consume();
        accept_in = 1'b1;
        @(posedge clk); #1;
        accept_in = 1'b0;
        chk("accept_after_consume", 128'(accept_out), 128'(1));
        chk("ready_after_consume", 128'(ready_out), 128'(0));
    endtask

    task automatic run_job(input logic [127:0] x, input logic [63:0] rd, input logic [63:0] ro,
                           input logic [127:0] ez);
        set_in(x, rd, ro);
        start_job(ez);
        wait_ready();
        consume();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_accept_out", 128'(accept_out), 128'(1));
        chk("rst_ready_out", 128'(ready_out), 128'(0));
        chk("rst_Z", Z, 128'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_job(X_NOM, RD_A, RO_A, Z_NOM);
        run_job(X_ALT, RD_B, RO_B, Z_ALT);
        run_job(X_SGN, RD_A, RO_A, Z_SGN);

        // backpressure: READY holds while enable toggles and X changes
        set_in(X_NOM, RD_A, RO_A);
        start_job(Z_NOM);
        wait_ready();
        for (int i = 0; i < 10; i++) begin
            enable = i[0];
            X = {4{32'h4000_0000 + 32'(i)}};
            @(posedge clk);
            @(negedge clk);
            chk("bp_ready_out", 128'(ready_out), 128'(1));
            chk("bp_accept_out", 128'(accept_out), 128'(0));
            chk("bp_Z_hold", Z, Z_NOM);
        end
        enable = 1'b0;
        consume();

        // back-to-back: enable with accept_in in READY is not captured
        set_in(X_SGN, RD_A, RO_A);
        start_job(Z_SGN);
        wait_ready();
        enable = 1'b1; accept_in = 1'b1; X = X_JNK;
        @(posedge clk); #1;
        accept_in = 1'b0;
        chk("b2b_idle_accept_out", 128'(accept_out), 128'(1));
        chk("b2b_Z_held_in_idle", Z, Z_SGN);
        X = X_BB;
        start_job(Z_BB);
        wait_ready();
        consume();

        // input capture: inputs change right after the capture edge
        set_in(X_NOM, RD_A, RO_A);
        start_job(Z_NOM);
        set_in(X_JNK, {2{32'h4040_0000}}, {2{32'h4040_0000}});
        wait_ready();
        consume();

        // reset during ACC_A discards the job
        set_in(X_SGN, RD_A, RO_A);
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_Z", Z, 128'(0));
        chk("midrst_ready_out", 128'(ready_out), 128'(0));
        chk("midrst_accept_out", 128'(accept_out), 128'(1));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_job(X_NOM, RD_A, RO_A, Z_NOM);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 128'(q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/remodulate_zf.md
Name: remodulate_zf

Overview:
Forward counterpart of the ZF back-substitution stages. It computes z = R·x for the 2x2 complex upper-triangular R of the QR decomposition, re-encoding a detected symbol vector x into the Q^H·y domain.
- Used for residual/consistency checking: compare z against the Q_processed vector.
- Used as a stimulus generator for the detector benches.
- Uses the same enable/accept_out and ready_out/accept_in handshake as the other ZF stages.
- Arithmetic is IEEE-754 single precision through the existing adder and mul cells.

Parameters:
none (FP32 datapath, fixed 2x2 geometry)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  upstream request; sampled only in IDLE
accept_out  output  1  high while block can take new inputs (state IDLE)
ready_out  output  1  high while Z is valid (state READY)
accept_in  input  1  downstream consumed Z; sampled only in READY
X  input  128  {x1, x2}; each complex is 64b {re[63:32], im[31:0]}
R_diag  input  64  {r11[63:32], r22[31:0]}, real FP32 diagonal
R_off  input  64  r12 complex {re, im}
Z  output  128  {z1, z2}, same packing as X

Behaviour:
- One clock, domain clk. Reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, all operand/accumulator registers 0, Z=0, ready_out=0, accept_out=1.
- accept_out = (state==IDLE), combinational. ready_out = (state==READY), combinational.
- States: IDLE -> MUL_Z2 -> MUL_DIAG -> ACC_A -> ACC_B -> READY -> IDLE.
  - IDLE: on enable=1, latch X, R_diag and R_off into internal registers and go to MUL_Z2. Otherwise stay. Upstream may change inputs after the capture edge.
  - MUL_Z2: z2_re <= r22*x2re; z2_im <= r22*x2im.
  - MUL_DIAG: acc_re <= r11*x1re; acc_im <= r11*x1im.
  - ACC_A: acc_re <= acc_re + r12re*x2re; acc_im <= acc_im + r12re*x2im.
  - ACC_B: Z <= {acc_re + (-(r12im*x2im)), acc_im + r12im*x2re, z2_re, z2_im}. Negation is a sign-bit flip.
  - READY: hold Z. On accept_in=1 go to IDLE, else stay.
- Resources: exactly two mul and two adder instances, time-multiplexed. Each state performs at most one mul->add chain per lane, combinationally, and registers the result.
- Latency: enable sampled at edge k -> ready_out high from edge k+4. Minimum of 6 cycles between successive accepts (includes 1 cycle in IDLE).
- Z is updated only on the ACC_B->READY edge. It holds its value through IDLE and the next computation until overwritten.
- enable outside IDLE is ignored. accept_in outside READY is ignored.
- enable and accept_in both high in READY: go to IDLE, enable is not captured. A new job starts on the first IDLE cycle with enable=1.
- reset_n asserted mid-operation: immediate return to reset values. The partial job is discarded and no ready_out pulse is produced.
- No rounding or exception handling beyond the adder/mul cells. NaN/Inf propagate as those cells produce them.

Decomposition:
- Shared package zf_pkg holds:
  - State encoding localparams (3 bits).
  - FP32 sign-flip helper.
  - Complex pack/unpack field ranges ([63:32] re, [31:0] im).
- Split into remodulate_zf_controller (FSM, handshake, one-hot stage strobes) and remodulate_zf_datapath (operand registers, muxes, mul/adder instances, Z).

Test Plan:
- Nominal: r11=0x40000000 (2.0), r22=0x3F800000 (1.0), r12={0x3F000000,0x3F000000} (0.5+0.5j), x1={0x3F800000,0}, x2={0,0x3F800000}, enable pulse -> ready_out rises 4 edges later; Z={0x3FC00000,0x3F000000,0x00000000,0x3F800000} (z1=1.5+0.5j, z2=j).
- Sign path: same R, x2={0xBF800000,0} (-1) -> Z={0x3FC00000,0xBF000000,0xBF800000,0x00000000} (z1=1.5-0.5j, z2=-1).
- Backpressure: hold accept_in=0 for 10 cycles in READY while pulsing enable and changing X -> ready_out stays 1, Z unchanged, accept_out stays 0. Assert accept_in -> accept_out=1 next cycle.
- Back-to-back: enable and accept_in high together in READY, then a new X on the next IDLE cycle -> the first result is consumed, the second job starts one cycle later, and the second Z matches the reference model.
- Input capture: change X and R one cycle after the enable edge -> Z reflects the captured values only.
- Reset mid-op: drop reset_n during ACC_A -> Z=0, ready_out=0, accept_out=1 immediately. After release, a nominal job completes correctly.
